// File: rtl/wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_cmd_master                                                            |
// | Wishbone B4 classic single-transfer master driven by a valid/ready       |
// | command stream; results return on a valid/ready response stream.         |
// | Optional watchdog: define WB_CMD_MASTER_TIMEOUT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUS  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic        we_q,      we_d;
    logic [31:0] adr_q,     adr_d;
    logic [31:0] dat_q,     dat_d;
    logic [3:0]  sel_q,     sel_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        w_abort;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned       c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX  = c_TO_W'(TIMEOUT);

    logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic              rsp_err_q, rsp_err_d;

    // Counter saturates so a stuck value can never wrap back below the terminal count.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if ((state_q == c_IDLE) && cmd_valid_i) begin
            to_cnt_d = '0;
        end else if ((state_q == c_BUS) && !wbm_ack_i && (to_cnt_q != c_TO_MAX)) begin
            to_cnt_d = to_cnt_q + c_TO_W'(1);
        end
    end

    // Ack beats the terminal count on the same edge.
    assign w_abort = (state_q == c_BUS) && !wbm_ack_i && (to_cnt_q == c_TO_LAST);

    always_comb begin
        rsp_err_d = rsp_err_q;
        if ((state_q == c_BUS) && wbm_ack_i) begin
            rsp_err_d = 1'b0;
        end else if (w_abort) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            to_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign w_abort          = 1'b0;
    assign rsp_err_o        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        case (state_q)
            c_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    state_d = c_BUS;
                end
            end
            c_BUS: begin
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    state_d   = c_RESP;
                end else if (w_abort) begin
                    rsp_dat_d = 32'h0;
                    state_d   = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready_i) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= c_IDLE;
            we_q      <= 1'b0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            rsp_dat_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    // cyc and stb come from the same state flop so they can never diverge.
    assign wbm_cyc_o   = (state_q == c_BUS);
    assign wbm_stb_o   = (state_q == c_BUS);
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign cmd_ready_o = (state_q == c_IDLE);
    assign rsp_valid_o = (state_q == c_RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign busy_o      = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_cmd_master                                                         |
// | Directed self-checking bench for wb_cmd_master (TIMEOUT = 8).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_cmd_master;

    localparam int unsigned c_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic        ack;
    logic [31:0] dat_i;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    wb_cmd_master #(.TIMEOUT(c_TIMEOUT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int ncyc;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;

        // Reset values
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy",      busy,      0);
        check("rst_cyc_stb",   {cyc, stb, we}, 0);
        check("rst_adr",       adr,       0);
        check("rst_dat",       dat_o,     0);
        check("rst_sel",       sel,       0);
        check("rst_rsp",       {rsp_valid, rsp_err}, 0);
        check("rst_rsp_dat",   rsp_dat,   0);
        rst_n = 1'b1;
        tick();

        // Zero-wait read
        offer(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check("rd_cyc_n1",  {cyc, stb}, 2'b11);
        check("rd_adr",     adr, 32'h3000_0004);
        check("rd_sel_we",  {sel, we}, {4'hF, 1'b0});
        check("rd_busy",    busy, 1);
        ack = 1'b1; dat_i = 32'hDEAD_BEEF;
        tick();
        ack = 1'b1; dat_i = 32'h1111_2222;
        check("rd_cyc_drop", {cyc, stb}, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_dat",  rsp_dat, 32'hDEAD_BEEF);
        check("rd_rsp_err",  rsp_err, 0);
        tick();
        ack = 1'b0; dat_i = '0;
        check("rd_resp_hold_dat", rsp_dat, 32'hDEAD_BEEF);
        check("rd_resp_hold_v",   {rsp_valid, cyc}, 2'b10);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_back_idle", {cmd_ready, rsp_valid, busy}, 3'b100);

        // Wait-state write with stalled response
        offer(1'b1, 32'h3000_0000, 32'h1234_5678, 4'h3);
        tick();
        offer(1'b0, 32'h3000_00FC, 32'hFFFF_FFFF, 4'hC);
        for (int i = 0; i < 5; i++) begin
            check("wr_bus_cyc",  {cyc, stb, we}, 3'b111);
            check("wr_bus_dat",  dat_o, 32'h1234_5678);
            check("wr_bus_sel",  sel, 4'h3);
            check("wr_bus_adr",  adr, 32'h3000_0000);
            check("wr_bus_refuse", cmd_ready, 0);
            ack   = (i == 4);
            dat_i = 32'hCAFE_F00D;
            tick();
        end
        ack = 1'b0;
        check("wr_cyc_drop", cyc, 0);
        check("wr_rsp_dat",  rsp_dat, 0);
        check("wr_rsp_err",  rsp_err, 0);
        for (int j = 0; j < 4; j++) begin
            check("wr_stall_valid",  rsp_valid, 1);
            check("wr_stall_refuse", cmd_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        check("wr_stall_valid5", rsp_valid, 1);
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("wr_back_idle", {cmd_ready, rsp_valid, cyc}, 3'b100);
        check("wr_hold_adr",  adr,   32'h3000_0000);
        check("wr_hold_dat",  dat_o, 32'h1234_5678);
        check("wr_hold_sel",  {sel, we}, {4'h3, 1'b1});

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // Timeout with no ack
        offer(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        dat_i = 32'hAAAA_5555;
        ncyc = 0;
        while (cyc && ncyc < 20) begin
            ncyc++;
            tick();
        end
        check("to_cyc_len",  ncyc, c_TIMEOUT);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err",  rsp_err, 1);
        check("to_rsp_dat",  rsp_dat, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("to_back_idle", cmd_ready, 1);
`else
        // No watchdog: the cycle waits indefinitely
        offer(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        repeat (20) tick();
        check("nto_cyc_held", {cyc, stb, rsp_valid, rsp_err}, 4'b1100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("nto_rst_idle", {cyc, cmd_ready}, 2'b01);
        tick();
`endif

        // Ack on the 8th BUS cycle: the ack wins over the terminal count
        offer(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("bd_cyc", cyc, 1);
            ack   = (i == 7);
            dat_i = 32'h0BAD_F00D;
            tick();
        end
        ack = 1'b0;
        check("bd_rsp_valid", rsp_valid, 1);
        check("bd_rsp_err",   rsp_err, 0);
        check("bd_rsp_dat",   rsp_dat, 32'h0BAD_F00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Spurious ack in IDLE
        ack = 1'b1; dat_i = 32'hFFFF_FFFF;
        tick();
        ack = 1'b0;
        check("sp_state", {cmd_ready, busy, cyc, rsp_valid}, 4'b1000);
        check("sp_rsp_dat", rsp_dat, 32'h0BAD_F00D);

        // Reset during BUS
        offer(1'b1, 32'h3000_0010, 32'h5555_AAAA, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check("mr_cyc1", cyc, 1);
        tick();
        check("mr_cyc2", cyc, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_drop", {cyc, stb, busy, rsp_valid}, 0);
        for (int k = 0; k < 3; k++) begin
            check("mr_no_rsp", {rsp_valid, cyc}, 0);
            tick();
        end
        offer(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        ack = 1'b1; dat_i = 32'h5A5A_A5A5;
        tick();
        ack = 1'b0;
        check("mr_next_valid", {rsp_valid, rsp_err}, 2'b10);
        check("mr_next_dat",   rsp_dat, 32'h5A5A_A5A5);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("mr_next_idle", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
